// File: rtl/game_flow_pkg.sv
// game_flow_pkg: shared game phase encoding and default frame-count constants
package game_flow_pkg;
    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        LEVEL_START = 3'd1,
        PLAYING     = 3'd2,
        PLAYER_DEAD = 3'd3,
        LEVEL_CLEAR = 3'd4,
        GAME_OVER   = 3'd5,
        WIN         = 3'd6
    } game_state_t;
    localparam int DEF_START_LIVES        = 3;
    localparam int DEF_NUM_LEVELS         = 4;
    localparam int DEF_LEVEL_START_FRAMES = 60;
    localparam int DEF_DEATH_FRAMES       = 90;
    localparam int DEF_CLEAR_FRAMES       = 120;
    localparam int DEF_END_FRAMES         = 180;
    localparam int DEF_TIMER_WIDTH        = 8;
endpackage

// File: rtl/game_flow_controller_frame_timer.sv
// frame_timer: counts startOfFrame pulses and flags the pulse that completes the programmed length
module frame_timer
    import game_flow_pkg::*;
#(
    parameter int TIMER_WIDTH = DEF_TIMER_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear,
    input  logic                   sof,
    input  logic [TIMER_WIDTH-1:0] last,
    output logic                   expire
);
    logic [TIMER_WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d  = clear ? '0 : sof ? cnt_q + TIMER_WIDTH'(1) : cnt_q;
        expire = sof && (cnt_q == last);
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
endmodule

// File: rtl/game_flow_controller.sv
// game_flow_controller: game phase sequencer owning level, lives and object hold/freeze controls
module game_flow_controller
    import game_flow_pkg::*;
#(
    parameter int START_LIVES        = DEF_START_LIVES,
    parameter int NUM_LEVELS         = DEF_NUM_LEVELS,
    parameter int LEVEL_START_FRAMES = DEF_LEVEL_START_FRAMES,
    parameter int DEATH_FRAMES       = DEF_DEATH_FRAMES,
    parameter int CLEAR_FRAMES       = DEF_CLEAR_FRAMES,
    parameter int END_FRAMES         = DEF_END_FRAMES,
    parameter int TIMER_WIDTH        = DEF_TIMER_WIDTH,
    localparam int LW  = (NUM_LEVELS > 1) ? $clog2(NUM_LEVELS) : 1,
    localparam int LVW = $clog2(START_LIVES + 1)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           startOfFrame,
    input  logic           start_req,
    input  logic           player_hit,
    input  logic           all_monsters_dead,
    input  logic           monsters_landed,
    output logic           objects_resetN,
    output logic           player_resetN,
    output logic           freeze,
    output logic           game_active,
    output logic [2:0]     state,
    output logic [LW-1:0]  level,
    output logic [LVW-1:0] lives
);
    localparam logic [TIMER_WIDTH-1:0] LS_LAST  = TIMER_WIDTH'(LEVEL_START_FRAMES - 1);
    localparam logic [TIMER_WIDTH-1:0] PD_LAST  = TIMER_WIDTH'(DEATH_FRAMES - 1);
    localparam logic [TIMER_WIDTH-1:0] LC_LAST  = TIMER_WIDTH'(CLEAR_FRAMES - 1);
    localparam logic [TIMER_WIDTH-1:0] END_LAST = TIMER_WIDTH'(END_FRAMES - 1);
    localparam logic [LW-1:0]          LVL_MAX  = LW'(NUM_LEVELS - 1);
    localparam logic [LVW-1:0]         LIVES0   = LVW'(START_LIVES);

    game_state_t            state_q, state_d;
    logic [LW-1:0]          level_q, level_d;
    logic [LVW-1:0]         lives_q, lives_d;
    logic                   obj_rn_q, obj_rn_d, ply_rn_q, ply_rn_d;
    logic                   freeze_q, freeze_d, active_q, active_d;
    logic [TIMER_WIDTH-1:0] t_last;
    logic                   t_clear, t_expire;

    frame_timer #(.TIMER_WIDTH(TIMER_WIDTH)) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (t_clear),
        .sof    (startOfFrame),
        .last   (t_last),
        .expire (t_expire)
    );

    always_comb begin
        state_d = state_q;
        level_d = level_q;
        lives_d = lives_q;
        t_last  = state_q == LEVEL_START ? LS_LAST :
                  state_q == PLAYER_DEAD ? PD_LAST :
                  state_q == LEVEL_CLEAR ? LC_LAST : END_LAST;
        case (state_q)
            LEVEL_START: if (t_expire) state_d = PLAYING;
            PLAYING: begin
                if (monsters_landed) begin
                    state_d = GAME_OVER;
                end else if (player_hit) begin
                    state_d = lives_q > LVW'(1) ? PLAYER_DEAD : GAME_OVER;
                    lives_d = lives_q > LVW'(1) ? lives_q - LVW'(1) : '0;
                end else if (all_monsters_dead) begin
                    state_d = LEVEL_CLEAR;
                end
            end
            PLAYER_DEAD: if (t_expire) state_d = PLAYING;
            LEVEL_CLEAR: if (t_expire) begin
                state_d = level_q == LVL_MAX ? WIN : LEVEL_START;
                level_d = level_q == LVL_MAX ? level_q : level_q + LW'(1);
            end
            GAME_OVER, WIN: if (t_expire) state_d = IDLE;
            default: if (start_req) begin
                state_d = LEVEL_START;
                level_d = '0;
                lives_d = LIVES0;
            end
        endcase
        // timer restarts on every phase change so each timed phase sees a fresh count
        t_clear  = state_d != state_q;
        obj_rn_d = state_d == PLAYING || state_d == PLAYER_DEAD;
        ply_rn_d = state_d == PLAYING || state_d == LEVEL_CLEAR;
        freeze_d = state_d != PLAYING;
        active_d = state_d == LEVEL_START || state_d == PLAYING ||
                   state_d == PLAYER_DEAD || state_d == LEVEL_CLEAR;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            level_q  <= '0;
            lives_q  <= LIVES0;
            obj_rn_q <= 1'b0;
            ply_rn_q <= 1'b0;
            freeze_q <= 1'b1;
            active_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            level_q  <= level_d;
            lives_q  <= lives_d;
            obj_rn_q <= obj_rn_d;
            ply_rn_q <= ply_rn_d;
            freeze_q <= freeze_d;
            active_q <= active_d;
        end
    end

    assign state          = state_q;
    assign level          = level_q;
    assign lives          = lives_q;
    assign objects_resetN = obj_rn_q;
    assign player_resetN  = ply_rn_q;
    assign freeze         = freeze_q;
    assign game_active    = active_q;
endmodule

// File: tb/tb_game_flow_controller.sv
// tb_game_flow_controller: directed plus random stimulus checked against a countdown reference model
module tb_game_flow_controller;
    localparam int SL = 2;
    localparam int NL = 2;
    localparam int F  = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sof = 1'b0, start_req = 1'b0, player_hit = 1'b0;
    logic       amd = 1'b0, landed = 1'b0;
    logic       orn, prn, freeze, game_active;
    logic [2:0] state;
    logic [0:0] level;
    logic [1:0] lives;

    int checks = 0;
    int errors = 0;
    int ms = 0, ml = 0, mv = SL, left = 0;

    game_flow_controller #(
        .START_LIVES(SL), .NUM_LEVELS(NL), .LEVEL_START_FRAMES(F),
        .DEATH_FRAMES(F), .CLEAR_FRAMES(F), .END_FRAMES(F), .TIMER_WIDTH(8)
    ) dut (
        .clk(clk), .rst(rst), .startOfFrame(sof), .start_req(start_req),
        .player_hit(player_hit), .all_monsters_dead(amd), .monsters_landed(landed),
        .objects_resetN(orn), .player_resetN(prn), .freeze(freeze),
        .game_active(game_active), .state(state), .level(level), .lives(lives)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic enter(input int ns);
        ms   = ns;
        left = F;
    endtask

    // Phase rules written as frames-remaining countdowns
    task automatic model(input bit s, input bit st, input bit h, input bit a, input bit l, input bit r);
        if (r) begin
            ms = 0; ml = 0; mv = SL; left = 0;
        end else if (ms == 2) begin
            if (l) enter(5);
            else if (h && mv == 1) begin enter(5); mv = 0; end
            else if (h) begin enter(3); mv--; end
            else if (a) enter(4);
        end else if (ms == 0 || ms == 7) begin
            if (st) begin enter(1); ml = 0; mv = SL; end
        end else if (s) begin
            left--;
            if (left == 0) begin
                if (ms == 1 || ms == 3) enter(2);
                else if (ms == 4 && ml == NL - 1) enter(6);
                else if (ms == 4) begin enter(1); ml++; end
                else enter(0);
            end
        end
    endtask

    task automatic step(input bit s, input bit st, input bit h, input bit a, input bit l, input bit r);
        @(negedge clk);
        sof = s; start_req = st; player_hit = h; amd = a; landed = l; rst = r;
        model(s, st, h, a, l, r);
        @(posedge clk);
        #1;
        chk("state", 8'(state), 8'(ms));
        chk("level", 8'(level), 8'(ml));
        chk("lives", 8'(lives), 8'(mv));
        chk("objects_resetN", 8'(orn), 8'(ms == 2 || ms == 3));
        chk("player_resetN", 8'(prn), 8'(ms == 2 || ms == 4));
        chk("freeze", 8'(freeze), 8'(ms != 2));
        chk("game_active", 8'(game_active), 8'(ms >= 1 && ms <= 4));
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0);
    endtask

    initial begin
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1);
        chk("rst_state", 8'(state), 8'd0);
        chk("rst_lives", 8'(lives), 8'd2);
        chk("rst_freeze", 8'(freeze), 8'd1);
        step(0, 1, 0, 0, 0, 0);
        chk("start_state", 8'(state), 8'd1);
        chk("start_orn", 8'(orn), 8'd0);
        frames(1);
        chk("ls_one_frame", 8'(state), 8'd1);
        frames(1);
        chk("play_state", 8'(state), 8'd2);
        chk("play_freeze", 8'(freeze), 8'd0);
        chk("play_prn", 8'(prn), 8'd1);
        step(0, 0, 1, 0, 0, 0);
        chk("dead_state", 8'(state), 8'd3);
        chk("dead_lives", 8'(lives), 8'd1);
        chk("dead_prn", 8'(prn), 8'd0);
        chk("dead_orn", 8'(orn), 8'd1);
        step(0, 0, 1, 0, 0, 0);
        chk("dead_hit_ignored", 8'(lives), 8'd1);
        frames(2);
        chk("respawn", 8'(state), 8'd2);
        step(0, 0, 1, 0, 0, 0);
        chk("gameover_state", 8'(state), 8'd5);
        chk("gameover_lives", 8'(lives), 8'd0);
        frames(2);
        chk("gameover_idle", 8'(state), 8'd0);
        step(0, 1, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0);
        chk("ls_hit_ignored", 8'(lives), 8'd2);
        frames(2);
        step(0, 1, 0, 0, 0, 0);
        chk("play_start_ignored", 8'(state), 8'd2);
        step(0, 0, 0, 1, 0, 0);
        chk("clear_state", 8'(state), 8'd4);
        chk("clear_orn", 8'(orn), 8'd0);
        step(0, 0, 1, 1, 0, 0);
        chk("clear_hit_ignored", 8'(lives), 8'd2);
        frames(2);
        chk("next_level_state", 8'(state), 8'd1);
        chk("next_level", 8'(level), 8'd1);
        frames(2);
        step(0, 0, 0, 1, 0, 0);
        frames(2);
        chk("win_state", 8'(state), 8'd6);
        chk("win_level", 8'(level), 8'd1);
        frames(2);
        chk("win_idle", 8'(state), 8'd0);
        chk("idle_level_kept", 8'(level), 8'd1);
        step(0, 1, 0, 0, 0, 0);
        frames(2);
        step(0, 0, 1, 1, 0, 0);
        chk("hit_beats_clear", 8'(state), 8'd3);
        chk("hit_beats_clear_lives", 8'(lives), 8'd1);
        frames(2);
        step(0, 0, 1, 0, 1, 0);
        chk("landed_state", 8'(state), 8'd5);
        chk("landed_lives", 8'(lives), 8'd1);
        frames(2);
        step(0, 1, 0, 0, 0, 0);
        frames(2);
        step(0, 0, 1, 0, 0, 0);
        frames(1);
        step(0, 0, 0, 0, 0, 1);
        chk("midrst_state", 8'(state), 8'd0);
        chk("midrst_lives", 8'(lives), 8'd2);
        chk("midrst_level", 8'(level), 8'd0);
        chk("midrst_freeze", 8'(freeze), 8'd1);
        step(0, 1, 0, 0, 0, 0);
        frames(1);
        chk("midrst_timer_clear", 8'(state), 8'd1);
        for (int i = 0; i < 4000; i++)
            step($urandom_range(2) == 0, $urandom_range(7) == 0, $urandom_range(9) == 0,
                 $urandom_range(11) == 0, $urandom_range(39) == 0, $urandom_range(199) == 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
